// File: rtl/vga_rx_if.sv
// Panel-side VGA signal bundle. The source drives it and the monitor only observes it.
`timescale 1ns/1ps
interface vga_rx_if #(
  parameter int PIX_W = 16
);
  // pix_en qualifies every other signal on the same clock. The monitor samples only
  // on strobe cycles and cannot stall the source, so there is no ready path.
  logic             pix_en;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [PIX_W-1:0] rgb;

  modport master (output pix_en, hsync, vsync, de, rgb);
  modport slave  (input  pix_en, hsync, vsync, de, rgb);
endinterface

// File: rtl/vga_rx_mon.sv
// Receive-side VGA monitor: measures line/frame timing, CRCs active pixels per frame,
// and declares lock once two consecutive frames carry identical timing.
`timescale 1ns/1ps
module vga_rx_mon #(
  parameter int PIX_W    = 16,
  parameter int CNT_W    = 12,
  parameter int SYNC_POL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vga_rx_if.slave          vga,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] meas_htotal_o,
  output logic [CNT_W-1:0] meas_hsync_o,
  output logic [CNT_W-1:0] meas_hact_o,
  output logic [CNT_W-1:0] meas_vtotal_o,
  output logic [CNT_W-1:0] meas_vsync_o,
  output logic [CNT_W-1:0] meas_vact_o,
  output logic [15:0]      frame_crc_o,
  output logic             frame_vld_o,
  output logic [15:0]      frame_cnt_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {SEEK, MEASURE, CHECK, LOCKED} state_t;

  localparam logic             POL  = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // CRC-16-CCITT, one pixel per call, MSB first.
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [PIX_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic             hs, vs, hs_q, vs_line_q;
  logic             line_start, frame_start, line_has_de;
  logic [CNT_W-1:0] hcnt, hsw, hde, hact_acc, vcnt, vsw, vact_cnt;
  logic [CNT_W-1:0] hact_new, vact_new;
  logic [15:0]      crc_acc, crc_base;
  logic [6*CNT_W-1:0] meas_now, ref_q;
  logic             match;

  state_t state_q, state_d;
  logic   publish, ref_load, err_set;

  assign hs = vga.hsync ~^ POL;
  assign vs = vga.vsync ~^ POL;

  assign line_start  = vga.pix_en & hs & ~hs_q;
  // vs is only looked at on line starts, so frame start is always also a line start.
  assign frame_start = line_start & vs & ~vs_line_q;

  // Values for the line that ends on this strobe, so a publish includes that line.
  assign line_has_de = (hde != '0);
  assign hact_new    = line_has_de ? hde : hact_acc;
  assign vact_new    = line_has_de ? sat_inc(vact_cnt) : vact_cnt;
  assign crc_base    = frame_start ? 16'hFFFF : crc_acc;

  assign meas_now = {hcnt, hsw, hact_new, vcnt, vsw, vact_new};
  assign match    = (meas_now == ref_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_q      <= 1'b0;
      vs_line_q <= 1'b0;
      hcnt      <= '0;
      hsw       <= '0;
      hde       <= '0;
      hact_acc  <= '0;
      vcnt      <= '0;
      vsw       <= '0;
      vact_cnt  <= '0;
      crc_acc   <= 16'hFFFF;
    end else if (vga.pix_en) begin
      hs_q <= hs;
      if (line_start) begin
        hcnt      <= ONE;
        hsw       <= ONE;
        hde       <= vga.de ? ONE : '0;
        vs_line_q <= vs;
        if (line_has_de) hact_acc <= hde;
        if (frame_start) begin
          vcnt     <= ONE;
          vsw      <= ONE;
          vact_cnt <= '0;
        end else begin
          vcnt     <= sat_inc(vcnt);
          vact_cnt <= vact_new;
          if (vs) vsw <= sat_inc(vsw);
        end
      end else begin
        hcnt <= sat_inc(hcnt);
        if (hs)     hsw <= sat_inc(hsw);
        if (vga.de) hde <= sat_inc(hde);
      end
      crc_acc <= vga.de ? crc_fold(crc_base, vga.rgb) : crc_base;
    end
  end

  always_comb begin
    state_d  = state_q;
    publish  = 1'b0;
    ref_load = 1'b0;
    err_set  = 1'b0;
    if (frame_start) begin
      case (state_q)
        SEEK: state_d = MEASURE;
        MEASURE: begin
          publish  = 1'b1;
          ref_load = 1'b1;
          state_d  = CHECK;
        end
        CHECK: begin
          publish = 1'b1;
          if (match) state_d = LOCKED;
          else       ref_load = 1'b1;
        end
        LOCKED: begin
          publish = 1'b1;
          if (!match) begin
            err_set  = 1'b1;
            ref_load = 1'b1;
            state_d  = CHECK;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SEEK;
      ref_q         <= '0;
      meas_htotal_o <= '0;
      meas_hsync_o  <= '0;
      meas_hact_o   <= '0;
      meas_vtotal_o <= '0;
      meas_vsync_o  <= '0;
      meas_vact_o   <= '0;
      frame_crc_o   <= '0;
      frame_vld_o   <= 1'b0;
      frame_cnt_o   <= '0;
      err_o         <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_vld_o <= publish;
      if (ref_load) ref_q <= meas_now;
      if (publish) begin
        {meas_htotal_o, meas_hsync_o, meas_hact_o,
         meas_vtotal_o, meas_vsync_o, meas_vact_o} <= meas_now;
        frame_crc_o <= crc_acc;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

  assign locked_o    = (state_q == LOCKED);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vga_rx_mon.sv
// Bench for vga_rx_mon: table of frames drives both an active-low and an active-high
// instance; each frame's expected measurements are queued and checked on frame_vld_o.
`timescale 1ns/1ps
module tb_vga_rx_mon;
  localparam int PIX_W = 16;
  localparam int CNT_W = 12;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i, err_clr_i;

  vga_rx_if #(.PIX_W(PIX_W)) vif0 ();
  vga_rx_if #(.PIX_W(PIX_W)) vif1 ();

  // second instance sees the same video with inverted sync polarity
  assign vif1.pix_en = vif0.pix_en;
  assign vif1.hsync  = ~vif0.hsync;
  assign vif1.vsync  = ~vif0.vsync;
  assign vif1.de     = vif0.de;
  assign vif1.rgb    = vif0.rgb;

  logic [CNT_W-1:0] o0_ht, o0_hs, o0_ha, o0_vt, o0_vs, o0_va;
  logic [CNT_W-1:0] o1_ht, o1_hs, o1_ha, o1_vt, o1_vs, o1_va;
  logic [15:0] o0_crc, o0_cnt, o1_crc, o1_cnt;
  logic o0_vld, o0_lock, o0_err, o1_vld, o1_lock, o1_err;
  logic [1:0] o0_st, o1_st;

  vga_rx_mon #(.PIX_W(PIX_W), .CNT_W(CNT_W), .SYNC_POL(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .vga(vif0.slave), .err_clr_i(err_clr_i),
    .meas_htotal_o(o0_ht), .meas_hsync_o(o0_hs), .meas_hact_o(o0_ha),
    .meas_vtotal_o(o0_vt), .meas_vsync_o(o0_vs), .meas_vact_o(o0_va),
    .frame_crc_o(o0_crc), .frame_vld_o(o0_vld), .frame_cnt_o(o0_cnt),
    .locked_o(o0_lock), .err_o(o0_err), .dbg_state_o(o0_st));

  vga_rx_mon #(.PIX_W(PIX_W), .CNT_W(CNT_W), .SYNC_POL(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .vga(vif1.slave), .err_clr_i(err_clr_i),
    .meas_htotal_o(o1_ht), .meas_hsync_o(o1_hs), .meas_hact_o(o1_ha),
    .meas_vtotal_o(o1_vt), .meas_vsync_o(o1_vs), .meas_vact_o(o1_va),
    .frame_crc_o(o1_crc), .frame_vld_o(o1_vld), .frame_cnt_o(o1_cnt),
    .locked_o(o1_lock), .err_o(o1_err), .dbg_state_o(o1_st));

  // mode: 0 zero pixels, 1 ramp, 2 random
  typedef struct {
    int htot, hsw, hact, vtot, vsw, vact, extra, mode, half, clr, exp_lock, exp_err;
  } row_t;

  typedef struct packed {
    logic [CNT_W-1:0] htot, hsw, hact, vtot, vsw, vact;
    logic [15:0]      crc;
    logic             lock, err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop;
  int total = 0;
  int bad = 0;
  int n_pub = 0;
  logic [15:0] crc_m;
  int ramp;
  row_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // driver tasks
  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      vif0.pix_en = 1'b0;
    end
  endtask

  task automatic drive_pix(input logic h, input logic v, input logic d,
                           input logic [15:0] px, input int half);
    @(negedge clk);
    vif0.pix_en = 1'b1;
    vif0.hsync  = ~h;
    vif0.vsync  = ~v;
    vif0.de     = d;
    vif0.rgb    = px;
    if (d) crc_m = crc_step(crc_m, px);
    if (half != 0) begin
      @(negedge clk);
      vif0.pix_en = 1'b0;
      vif0.hsync  = 1'($urandom_range(0, 1));
      vif0.vsync  = 1'($urandom_range(0, 1));
      vif0.de     = 1'($urandom_range(0, 1));
      vif0.rgb    = 16'($urandom);
    end
  endtask

  task automatic drive_frame(input row_t r, input int max_lines);
    int w;
    logic d;
    logic [15:0] px;
    crc_m = 16'hFFFF;
    ramp  = 0;
    for (int y = 0; y < r.vtot && y < max_lines; y++) begin
      w = r.htot + ((y == r.vtot - 1) ? r.extra : 0);
      for (int x = 0; x < w; x++) begin
        d  = (y >= r.vtot - r.vact) && (x >= r.htot - r.hact) && (x < r.htot);
        px = (r.mode == 0) ? 16'h0000 : (r.mode == 1) ? ramp[15:0] : 16'($urandom);
        if (d) ramp++;
        drive_pix(x < r.hsw, y < r.vsw, d, px, r.half);
      end
    end
  endtask

  task automatic push_exp(input row_t r);
    exp_t e;
    int t;
    t = r.htot + r.extra;
    if (t > 4095) t = 4095;
    e.htot = CNT_W'(t);
    e.hsw  = CNT_W'(r.hsw);
    e.hact = CNT_W'(r.hact);
    e.vtot = CNT_W'(r.vtot);
    e.vsw  = CNT_W'(r.vsw);
    e.vact = CNT_W'(r.vact);
    e.crc  = crc_m;
    e.lock = 1'(r.exp_lock);
    e.err  = 1'(r.exp_err);
    exp_q.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ht"},  o0_ht, 0);   chk({tag, "_hs"},  o0_hs, 0);
    chk({tag, "_ha"},  o0_ha, 0);   chk({tag, "_vt"},  o0_vt, 0);
    chk({tag, "_vs"},  o0_vs, 0);   chk({tag, "_va"},  o0_va, 0);
    chk({tag, "_crc"}, o0_crc, 0);  chk({tag, "_vld"}, o0_vld, 0);
    chk({tag, "_cnt"}, o0_cnt, 0);  chk({tag, "_lock"}, o0_lock, 0);
    chk({tag, "_err"}, o0_err, 0);  chk({tag, "_st"},  o0_st, 0);
    chk({tag, "_lock1"}, o1_lock, 0); chk({tag, "_cnt1"}, o1_cnt, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  // scoreboard: one expected record per frame_vld_o pulse
  always @(posedge clk) begin
    #1;
    if (!rst_i && (o0_vld || o1_vld)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld: got vld0=%0b vld1=%0b want no pulse", o0_vld, o1_vld);
      end else begin
        e_pop = exp_q.pop_front();
        n_pub++;
        chk("vld0", o0_vld, 1);        chk("vld1", o1_vld, 1);
        chk("htotal", o0_ht, e_pop.htot); chk("hsync", o0_hs, e_pop.hsw);
        chk("hact", o0_ha, e_pop.hact);   chk("vtotal", o0_vt, e_pop.vtot);
        chk("vsync", o0_vs, e_pop.vsw);   chk("vact", o0_va, e_pop.vact);
        chk("crc", o0_crc, e_pop.crc);    chk("locked", o0_lock, e_pop.lock);
        chk("err", o0_err, e_pop.err);    chk("frame_cnt", o0_cnt, 16'(n_pub));
        chk("htotal_p1", o1_ht, e_pop.htot); chk("hsync_p1", o1_hs, e_pop.hsw);
        chk("hact_p1", o1_ha, e_pop.hact);   chk("vtotal_p1", o1_vt, e_pop.vtot);
        chk("vsync_p1", o1_vs, e_pop.vsw);   chk("vact_p1", o1_va, e_pop.vact);
        chk("crc_p1", o1_crc, e_pop.crc);    chk("locked_p1", o1_lock, e_pop.lock);
        chk("err_p1", o1_err, e_pop.err);
      end
    end
  end

  initial begin
    row_t base;
    vif0.pix_en = 1'b0;
    vif0.hsync  = 1'b1;
    vif0.vsync  = 1'b1;
    vif0.de     = 1'b0;
    vif0.rgb    = '0;
    err_clr_i   = 1'b0;
    rst_i       = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_i = 1'b0;

    //         htot hsw hact vtot vsw vact extra mode half clr lock err
    tbl[0]  = '{10, 2, 6, 8, 1, 5,    0, 0, 0, 0, 0, 0};
    tbl[1]  = '{10, 2, 6, 8, 1, 5,    0, 0, 0, 0, 1, 0};
    tbl[2]  = '{10, 2, 6, 8, 1, 5,    0, 1, 0, 0, 1, 0};
    tbl[3]  = '{10, 2, 6, 8, 1, 5,    0, 1, 0, 0, 1, 0};
    tbl[4]  = '{11, 2, 6, 8, 1, 5,    0, 1, 0, 0, 0, 1};
    tbl[5]  = '{11, 2, 6, 8, 1, 5,    0, 1, 0, 0, 1, 1};
    tbl[6]  = '{11, 2, 6, 8, 1, 5,    0, 1, 0, 0, 1, 0};
    tbl[7]  = '{10, 2, 6, 8, 1, 5,    0, 1, 1, 1, 0, 1};
    tbl[8]  = '{10, 2, 6, 8, 1, 5,    0, 1, 1, 0, 1, 1};
    tbl[9]  = '{10, 2, 6, 8, 1, 5,    0, 0, 1, 0, 1, 1};
    tbl[10] = '{10, 2, 6, 8, 1, 5,    0, 2, 0, 0, 1, 1};
    tbl[11] = '{12, 3, 8, 6, 2, 3,    0, 1, 0, 0, 0, 1};
    tbl[12] = '{12, 3, 8, 6, 2, 3, 5000, 1, 0, 0, 0, 1};

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].clr != 0) begin
        @(negedge clk);
        vif0.pix_en = 1'b0;
        err_clr_i   = 1'b1;
        @(negedge clk);
        err_clr_i   = 1'b0;
        chk("err_clr", o0_err, 0);
        chk("err_clr_p1", o1_err, 0);
      end
      drive_frame(tbl[i], 1 << 20);
      push_exp(tbl[i]);
    end
    // a bare frame start publishes the last table frame
    drive_pix(1'b1, 1'b1, 1'b0, 16'h0, 0);
    hold(4);
    drain("drain_table");

    // reset in the middle of a locked frame
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    n_pub = 0;
    base = '{10, 2, 6, 8, 1, 5, 0, 1, 0, 0, 0, 0};
    drive_frame(base, 1 << 20);
    push_exp(base);
    base.exp_lock = 1;
    drive_frame(base, 1 << 20);
    push_exp(base);
    drive_frame(base, 3);
    chk("locked_pre_rst", o0_lock, 1);
    chk("queue_pre_rst", exp_q.size(), 0);
    @(negedge clk);
    vif0.pix_en = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst_i = 1'b0;
    n_pub = 0;
    hold(20);
    drain("drain_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
